// File: rtl/loteria_sorteador_pkg.sv
// loteria_sorteador_pkg: shared state encoding, 7-segment table and digit helpers
package loteria_sorteador_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DRAW, S_READY, S_SEND, S_FIN, S_DONE} state_t;
  localparam int unsigned NDIG = 5;
  localparam logic [3:0] DIG_DASH = 4'd10;
  localparam logic [3:0] DIG_P = 4'd11;
  // Active-low gfedcba, shared with the checker: 0-9, then '-' and 'P'
  localparam logic [6:0] SEG_TAB [12] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
    7'b0111111, 7'b0001100
  };
  function automatic logic [6:0] seg7(input logic [3:0] d);
    return (d < 4'd12) ? SEG_TAB[d] : 7'b1111111;
  endfunction
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction
endpackage

// File: rtl/loteria_sorteador_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, taps 16,14,13,11; a zero seed becomes 1
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= (seed == 16'h0) ? 16'h0001 : seed;
    else q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
endmodule

// File: rtl/loteria_sorteador_seg7_dec.sv
// seg7_dec: digit code to active-low 7-segment pattern
module seg7_dec
  import loteria_sorteador_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  always_comb seg_o = seg7(bcd_i);
endmodule

// File: rtl/loteria_sorteador.sv
// loteria_sorteador: draws or presets a 5-digit BCD number and plays it out as insert/finish pulses
module loteria_sorteador
  import loteria_sorteador_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int unsigned GAP  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        draw,
  input  logic        preset,
  input  logic [19:0] preset_bcd,
  input  logic        send,
  output logic [3:0]  num_out,
  output logic        insert_out,
  output logic        finish_out,
  output logic        busy,
  output logic        done,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX0,
  output logic [8:0]  LEDR
);
  localparam logic [3:0] GAP_C = 4'(GAP);
  state_t state_q, state_d;
  logic [2:0] k_q, k_d, n;
  logic [3:0] c_q, c_d, cand, num_d;
  logic [4:0][3:0] dig_q, dig_d;
  logic [4:0][6:0] seg_w;
  logic [15:0] lfsr_w;
  logic unused_lfsr;
  logic ins_d, fin_d, busy_d, done_d;
  logic [8:0] ledr_d;
  lfsr16 u_lfsr (.clk(clk), .reset(reset), .seed(SEED), .q(lfsr_w));
  assign cand = lfsr_w[3:0];
  assign unused_lfsr = ^lfsr_w[15:4];
  for (genvar g = 0; g < NDIG; g++) begin : g_seg
    seg7_dec u_seg (.bcd_i(dig_q[g]), .seg_o(seg_w[g]));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      k_q <= '0;
      c_q <= '0;
      dig_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      c_q <= c_d;
      dig_q <= dig_d;
    end
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    c_d = c_q;
    dig_d = dig_q;
    case (state_q)
      S_IDLE, S_READY, S_DONE: begin
        if (preset) begin
          for (int j = 0; j < NDIG; j++) dig_d[j] = bcd_clamp(preset_bcd[19-4*j -: 4]);
          k_d = 3'd5;
          state_d = S_READY;
        end else if (draw) begin
          dig_d = '0;
          k_d = '0;
          state_d = S_DRAW;
        end else if (state_q == S_READY && send) begin
          k_d = '0;
          c_d = '0;
          state_d = S_SEND;
        end
      end
      S_DRAW: if (cand <= 4'd9) begin
        dig_d[k_q] = cand;
        k_d = k_q + 3'd1;
        state_d = (k_q == 3'd4) ? S_READY : S_DRAW;
      end
      // Each digit occupies GAP+1 cycles; the pulse goes out on count 0
      S_SEND: begin
        c_d = (c_q == GAP_C) ? 4'd0 : c_q + 4'd1;
        k_d = (c_q == GAP_C) ? k_q + 3'd1 : k_q;
        state_d = (c_q == GAP_C && k_q == 3'd4) ? S_FIN : S_SEND;
      end
      S_FIN: begin
        c_d = (c_q == GAP_C) ? 4'd0 : c_q + 4'd1;
        state_d = (c_q == GAP_C) ? S_DONE : S_FIN;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    ins_d = state_q == S_SEND && c_q == 4'd0;
    fin_d = state_q == S_FIN && c_q == 4'd0;
    num_d = ins_d ? dig_q[k_q] : num_out;
    busy_d = state_q inside {S_DRAW, S_SEND, S_FIN};
    done_d = state_q == S_DONE;
    n = (state_q == S_SEND) ? k_q + 3'd1 :
        (state_q inside {S_FIN, S_DONE}) ? 3'd5 :
        (state_q inside {S_DRAW, S_READY}) ? k_q : 3'd0;
    ledr_d = {done_d, 3'b000, 5'((6'd1 << n) - 6'd1)};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      num_out <= '0;
      insert_out <= 1'b0;
      finish_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      LEDR <= '0;
      HEX4 <= SEG_TAB[0];
      HEX3 <= SEG_TAB[0];
      HEX2 <= SEG_TAB[0];
      HEX1 <= SEG_TAB[0];
      HEX0 <= SEG_TAB[0];
    end else begin
      num_out <= num_d;
      insert_out <= ins_d;
      finish_out <= fin_d;
      busy <= busy_d;
      done <= done_d;
      LEDR <= ledr_d;
      HEX4 <= seg_w[0];
      HEX3 <= seg_w[1];
      HEX2 <= seg_w[2];
      HEX1 <= seg_w[3];
      HEX0 <= seg_w[4];
    end
endmodule

// File: tb/tb_loteria_sorteador.sv
// tb_loteria_sorteador: directed bench with a pulse-train scoreboard for GAP=2 and GAP=1 instances
module tb_loteria_sorteador;
  logic clk = 0, reset = 1, draw = 0, preset = 0, send = 0;
  logic [19:0] preset_bcd = '0;
  logic [3:0] num1, num2;
  logic ins1, ins2, fin1, fin2, busy1, busy2, done1, done2;
  logic [6:0] h1 [5], h2 [5];
  logic [8:0] led1, led2;
  int errors = 0, checks = 0, cyc = 0, c0 = 0;
  int n_ev [2] = '{0, 0};
  typedef struct {int cyc; logic [3:0] num; logic fin;} ev_t;
  ev_t q1 [$], q2 [$];
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or posedge reset)
    if (reset) m_lfsr <= 16'hACE1;
    else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  loteria_sorteador #(.SEED(16'hACE1), .GAP(2)) u1 (
    .clk(clk), .reset(reset), .draw(draw), .preset(preset), .preset_bcd(preset_bcd), .send(send),
    .num_out(num1), .insert_out(ins1), .finish_out(fin1), .busy(busy1), .done(done1),
    .HEX4(h1[4]), .HEX3(h1[3]), .HEX2(h1[2]), .HEX1(h1[1]), .HEX0(h1[0]), .LEDR(led1));
  loteria_sorteador #(.SEED(16'hACE1), .GAP(1)) u2 (
    .clk(clk), .reset(reset), .draw(draw), .preset(preset), .preset_bcd(preset_bcd), .send(send),
    .num_out(num2), .insert_out(ins2), .finish_out(fin2), .busy(busy2), .done(done2),
    .HEX4(h2[4]), .HEX3(h2[3]), .HEX2(h2[2]), .HEX1(h2[1]), .HEX0(h2[0]), .LEDR(led2));

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40; 4'd1: return 7'h79; 4'd2: return 7'h24; 4'd3: return 7'h30;
      4'd4: return 7'h19; 4'd5: return 7'h12; 4'd6: return 7'h02; 4'd7: return 7'h78;
      4'd8: return 7'h00; 4'd9: return 7'h10; default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic fin, input logic [3:0] num);
    ev_t e;
    logic got = 0;
    n_ev[d]++;
    if (d == 0 && q1.size() > 0) begin e = q1.pop_front(); got = 1; end
    if (d == 1 && q2.size() > 0) begin e = q2.pop_front(); got = 1; end
    if (!got) chk($sformatf("unexpected_pulse_dut%0d", d), cyc, 32'hFFFFFFFF);
    else begin
      chk($sformatf("pulse_cycle_dut%0d", d), cyc, e.cyc);
      chk($sformatf("pulse_num_dut%0d", d), {28'd0, num}, {28'd0, e.num});
      chk($sformatf("pulse_kind_dut%0d", d), {31'd0, fin}, {31'd0, e.fin});
    end
  endtask

  always @(negedge clk) begin
    if (ins1 || fin1) mon(0, fin1, num1);
    if (ins2 || fin2) mon(1, fin2, num2);
  end

  // Called at a negedge with send already high: the next posedge samples it
  task automatic do_send(input logic [19:0] v);
    send = 1;
    c0 = cyc + 1;
    for (int i = 0; i < 5; i++) begin
      q1.push_back('{c0 + 1 + i * 3, v[19-4*i -: 4], 1'b0});
      q2.push_back('{c0 + 1 + i * 2, v[19-4*i -: 4], 1'b0});
    end
    q1.push_back('{c0 + 16, v[3:0], 1'b1});
    q2.push_back('{c0 + 11, v[3:0], 1'b1});
    @(negedge clk);
    send = 0;
  endtask

  task automatic chk_hex(input logic [19:0] v);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hex%0d_dut0", 4 - i), {25'd0, h1[4-i]}, {25'd0, seg(v[19-4*i -: 4])});
      chk($sformatf("hex%0d_dut1", 4 - i), {25'd0, h2[4-i]}, {25'd0, seg(v[19-4*i -: 4])});
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(done1 && done2) && n < 100) begin @(negedge clk); n++; end
    chk("wait_done", {30'd0, done1, done2}, 32'd3);
  endtask

  initial begin
    logic [3:0] cand;
    logic [3:0] e_d [5];
    logic [19:0] v;
    int acc = 0, skip = 0, ne;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_num", {28'd0, num1}, 0);
    chk("rst_insert", {31'd0, ins1}, 0);
    chk("rst_finish", {31'd0, fin1}, 0);
    chk("rst_busy", {31'd0, busy1}, 0);
    chk("rst_done", {31'd0, done1}, 0);
    chk("rst_ledr", {23'd0, led1}, 0);
    chk_hex(20'h00000);

    // Preset 50967 and transmit
    preset_bcd = 20'h50967;
    preset = 1;
    @(negedge clk);
    preset = 0;
    @(negedge clk);
    chk_hex(20'h50967);
    chk("ready_ledr", {23'd0, led1}, 32'h1F);
    chk("ready_busy", {31'd0, busy1}, 0);
    do_send(20'h50967);
    while (cyc < c0 + 20) begin
      if (cyc == c0 + 5) begin
        chk("send_busy", {31'd0, busy1}, 1);
        chk("send_ledr_dut0", {23'd0, led1}, 32'h003);
        chk("send_ledr_dut1", {23'd0, led2}, 32'h007);
      end
      if (cyc == c0 + 18) chk("done_early", {31'd0, done1}, 0);
      if (cyc == c0 + 19) begin
        chk("done_on_time", {31'd0, done1}, 1);
        chk("done_ledr", {23'd0, led1}, 32'h11F);
        chk("done_num_hold", {28'd0, num1}, 7);
        chk("done_busy", {31'd0, busy1}, 0);
      end
      @(negedge clk);
    end

    // Random draw against the LFSR model
    draw = 1;
    @(negedge clk);
    draw = 0;
    for (int i = 0; i < 300 && acc < 5; i++) begin
      cand = m_lfsr[3:0];
      if (cand <= 4'd9) begin e_d[acc] = cand; acc++; end
      else skip++;
      if (acc < 5) @(negedge clk);
    end
    @(negedge clk);
    chk("draw_busy_last", {31'd0, busy1}, 1);
    @(negedge clk);
    chk("draw_ready_dut0", {31'd0, busy1}, 0);
    chk("draw_ready_dut1", {31'd0, busy2}, 0);
    chk("draw_ledr", {23'd0, led1}, 32'h1F);
    v = {e_d[0], e_d[1], e_d[2], e_d[3], e_d[4]};
    chk_hex(v);

    // Send the drawn number while hammering the controls
    do_send(v);
    while (cyc < c0 + 12) begin
      draw = 1'($urandom);
      preset = 1'($urandom);
      send = 1'($urandom);
      preset_bcd = 20'($urandom);
      @(negedge clk);
    end
    draw = 0;
    preset = 0;
    send = 0;
    wait_done();
    ne = n_ev[0] + n_ev[1];
    send = 1;
    repeat (10) @(negedge clk);
    send = 0;
    chk("no_retransmit", n_ev[0] + n_ev[1], ne);
    chk("still_done", {31'd0, done1}, 1);

    // Reset after the third insert
    preset_bcd = 20'h50967;
    preset = 1;
    @(negedge clk);
    preset = 0;
    @(negedge clk);
    do_send(20'h50967);
    while (cyc < c0 + 7) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("arst_insert", {31'd0, ins1}, 0);
    chk("arst_insert_dut1", {31'd0, ins2}, 0);
    chk("arst_num", {28'd0, num1}, 0);
    chk("arst_busy", {31'd0, busy1}, 0);
    chk("arst_ledr", {23'd0, led1}, 0);
    q1.delete();
    q2.delete();
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("post_rst_ledr", {23'd0, led1}, 0);
    chk("post_rst_done", {31'd0, done1}, 0);

    // Preset beats draw in IDLE
    preset_bcd = 20'h50960;
    preset = 1;
    draw = 1;
    @(negedge clk);
    preset = 0;
    draw = 0;
    @(negedge clk);
    chk("preset_wins_dut0", {31'd0, busy1}, 0);
    chk("preset_wins_dut1", {31'd0, busy2}, 0);
    chk_hex(20'h50960);
    do_send(20'h50960);
    wait_done();

    // Out-of-range digits clamp to 9
    preset_bcd = 20'hFFFFF;
    preset = 1;
    @(negedge clk);
    preset = 0;
    @(negedge clk);
    chk_hex(20'h99999);
    do_send(20'h99999);
    wait_done();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q1.size() + q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
